// File: rtl/id_stage.sv
// Decode stage: IF/ID latch, 32-entry register file with WB bypass, branch/jump resolution.
// Decode outputs are combinational from the latch (fetch->decode = 1 cycle); i_step=0 or i_if_id_write=0 holds the latch and suppresses o_branch.
module id_stage #(
   parameter int NB     = 32,
   parameter int NB_REG = 5
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_step,
   input  logic              i_if_id_write,
   input  logic              i_flush,
   input  logic [NB-1:0]     i_instruction,
   input  logic [NB-1:0]     i_pc4,
   input  logic [NB-1:0]     i_pc8,
   input  logic              i_wb_write,
   input  logic [NB_REG-1:0] i_wb_addr,
   input  logic [NB-1:0]     i_wb_data,
   input  logic [NB_REG-1:0] i_debug_addr,
   output logic [NB-1:0]     o_debug_data,
   output logic [NB-1:0]     o_instruction,
   output logic [NB-1:0]     o_pc8,
   output logic [NB_REG-1:0] o_rs,
   output logic [NB_REG-1:0] o_rt,
   output logic [NB_REG-1:0] o_rd,
   output logic [5:0]        o_opcode,
   output logic [5:0]        o_funct,
   output logic [NB-1:0]     o_rs_data,
   output logic [NB-1:0]     o_rt_data,
   output logic [NB-1:0]     o_imm_ext,
   output logic              o_branch,
   output logic [NB-1:0]     o_branch_addr
);

   localparam int NUM_REGS = 2 ** NB_REG;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] FN_JR      = 6'b001000;
   localparam logic [5:0] FN_JALR    = 6'b001001;

   logic [NB-1:0] instr_q, instr_d;
   logic [NB-1:0] pc4_q, pc4_d;
   logic [NB-1:0] pc8_q, pc8_d;
   logic [NB-1:0] regs_q [NUM_REGS];
   logic [NB-1:0] regs_d [NUM_REGS];

   logic [NB-1:0] instr;
   logic [NB-1:0] branch_tgt;
   logic [NB-1:0] jump_tgt;
   logic          taken;

   // Read port: register 0 is hard zero, a same-cycle WB write is forwarded,
   // and everything reads zero while reset is held.
   function automatic logic [NB-1:0] read_port(input logic [NB_REG-1:0] addr);
      logic [NB-1:0] val;
      val = '0;
      if (i_reset || addr == '0) begin
         val = '0;
      end else if (i_wb_write && i_wb_addr == addr) begin
         val = i_wb_data;
      end else begin
         val = regs_q[addr];
      end
      return val;
   endfunction

   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      pc8_d   = pc8_q;
      if (i_step) begin
         if (i_flush) begin
            instr_d = '0;
            pc4_d   = '0;
            pc8_d   = '0;
         end else if (i_if_id_write) begin
            instr_d = i_instruction;
            pc4_d   = i_pc4;
            pc8_d   = i_pc8;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (i_step && i_wb_write && i_wb_addr != '0) begin
         regs_d[i_wb_addr] = i_wb_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         instr_q <= '0;
         pc4_q   <= '0;
         pc8_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         pc8_q   <= pc8_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign instr = i_reset ? '0 : instr_q;

   always_comb begin
      o_instruction = instr;
      o_pc8         = i_reset ? '0 : pc8_q;
      o_opcode      = instr[31:26];
      o_rs          = instr[25:21];
      o_rt          = instr[20:16];
      o_rd          = instr[15:11];
      o_funct       = instr[5:0];
      o_imm_ext     = {{(NB-16){instr[15]}}, instr[15:0]};
      o_rs_data     = read_port(instr[25:21]);
      o_rt_data     = read_port(instr[20:16]);
      o_debug_data  = read_port(i_debug_addr);
   end

   assign branch_tgt = pc4_q + (o_imm_ext << 2);
   assign jump_tgt   = {pc4_q[NB-1:28], instr[25:0], 2'b00};

   always_comb begin
      taken         = 1'b0;
      o_branch_addr = '0;
      unique case (o_opcode)
         OP_BEQ: begin
            taken         = (o_rs_data == o_rt_data);
            o_branch_addr = branch_tgt;
         end
         OP_BNE: begin
            taken         = (o_rs_data != o_rt_data);
            o_branch_addr = branch_tgt;
         end
         OP_J, OP_JAL: begin
            taken         = 1'b1;
            o_branch_addr = jump_tgt;
         end
         OP_SPECIAL: begin
            if (o_funct == FN_JR || o_funct == FN_JALR) begin
               taken         = 1'b1;
               o_branch_addr = o_rs_data;
            end
         end
         default: begin
            taken         = 1'b0;
            o_branch_addr = '0;
         end
      endcase
   end

   // A stalled decode must not redirect fetch.
   assign o_branch = taken && i_step && i_if_id_write && !i_reset;

endmodule

// File: tb/tb_id_stage.sv
// Directed table-driven bench for id_stage: decode, register file, bypass, branch resolution, stall/flush/reset.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst, step, ifw, flush;
   logic [31:0] instruction, pc4, pc8;
   logic        wb_write;
   logic [4:0]  wb_addr, debug_addr;
   logic [31:0] wb_data;
   logic [31:0] debug_data, o_instruction, o_pc8, rs_data, rt_data, imm_ext, branch_addr;
   logic [4:0]  o_rs, o_rt, o_rd;
   logic [5:0]  opcode, funct;
   logic        branch;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   id_stage #(.NB(32), .NB_REG(5)) dut (
      .i_clk(clk), .i_reset(rst), .i_step(step), .i_if_id_write(ifw), .i_flush(flush),
      .i_instruction(instruction), .i_pc4(pc4), .i_pc8(pc8),
      .i_wb_write(wb_write), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
      .i_debug_addr(debug_addr), .o_debug_data(debug_data),
      .o_instruction(o_instruction), .o_pc8(o_pc8),
      .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_opcode(opcode), .o_funct(funct),
      .o_rs_data(rs_data), .o_rt_data(rt_data), .o_imm_ext(imm_ext),
      .o_branch(branch), .o_branch_addr(branch_addr)
   );

   typedef struct packed {
      logic        rst;
      logic        step;
      logic        ifw;
      logic        fl;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic [31:0] pc8;
      logic        wbw;
      logic [4:0]  wba;
      logic [31:0] wbd;
      logic [4:0]  dba;
      logic [31:0] e_instr;
      logic        e_br;
      logic        chk_ba;
      logic [31:0] e_ba;
      logic [31:0] e_dbg;
      logic [31:0] e_pc8;
   } vec_t;

   localparam int NV = 19;
   vec_t vec [NV];

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst         = v.rst;
      step        = v.step;
      ifw         = v.ifw;
      flush       = v.fl;
      instruction = v.instr;
      pc4         = v.pc4;
      pc8         = v.pc8;
      wb_write    = v.wbw;
      wb_addr     = v.wba;
      wb_data     = v.wbd;
      debug_addr  = v.dba;
   endtask

   initial begin
      //          rst   step  ifw   fl    instr         pc4           pc8           wbw   wba    wbd           dba     e_instr       e_br  chk   e_ba          e_dbg         e_pc8
      vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        5'd0,   32'h0,        1'b0, 1'b1, 32'h0,        32'h0,        32'h0};
      vec[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        32'h0,        1'b1, 5'd8,  32'h5,        5'd8,   32'h0,        1'b0, 1'b1, 32'h0,        32'h5,        32'h0};
      vec[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h11090003, 32'h10,       32'h14,       1'b1, 5'd9,  32'h5,        5'd8,   32'h11090003, 1'b1, 1'b1, 32'h1C,       32'h5,        32'h14};
      vec[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h11090003, 32'h10,       32'h14,       1'b1, 5'd9,  32'h6,        5'd9,   32'h11090003, 1'b0, 1'b0, 32'h0,        32'h6,        32'h14};
      vec[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h1509FFFF, 32'h10,       32'h14,       1'b0, 5'd0,  32'h0,        5'd9,   32'h1509FFFF, 1'b1, 1'b1, 32'h0C,       32'h6,        32'h14};
      vec[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h08000040, 32'h40000004, 32'h40000008, 1'b0, 5'd0,  32'h0,        5'd8,   32'h08000040, 1'b1, 1'b1, 32'h40000100, 32'h5,        32'h40000008};
      vec[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h01000008, 32'h44,       32'h48,       1'b1, 5'd8,  32'hAF,       5'd8,   32'h01000008, 1'b1, 1'b1, 32'hAF,       32'hAF,       32'h48};
      vec[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h48,       32'h4C,       1'b1, 5'd0,  32'h1234,     5'd0,   32'h0,        1'b0, 1'b1, 32'h0,        32'h0,        32'h4C};
      vec[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h4C,       32'h50,       1'b1, 5'd3,  32'hDEAD,     5'd3,   32'h0,        1'b0, 1'b1, 32'h0,        32'hDEAD,     32'h50};
      vec[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0C000010, 32'h20,       32'h24,       1'b0, 5'd0,  32'h0,        5'd3,   32'h0C000010, 1'b1, 1'b1, 32'h40,       32'hDEAD,     32'h24};
      vec[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h11090003, 32'h60,       32'h64,       1'b0, 5'd0,  32'h0,        5'd3,   32'h0C000010, 1'b0, 1'b0, 32'h0,        32'hDEAD,     32'h24};
      vec[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h11090003, 32'h60,       32'h64,       1'b0, 5'd0,  32'h0,        5'd3,   32'h0C000010, 1'b0, 1'b0, 32'h0,        32'hDEAD,     32'h24};
      vec[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h11090003, 32'h60,       32'h64,       1'b0, 5'd0,  32'h0,        5'd3,   32'h0,        1'b0, 1'b1, 32'h0,        32'hDEAD,     32'h0};
      vec[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h08000040, 32'h70,       32'h74,       1'b1, 5'd3,  32'h5555,     5'd9,   32'h0,        1'b0, 1'b1, 32'h0,        32'h6,        32'h0};
      vec[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h08000040, 32'h70,       32'h74,       1'b0, 5'd0,  32'h0,        5'd3,   32'h0,        1'b0, 1'b1, 32'h0,        32'hDEAD,     32'h0};
      vec[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h10630001, 32'h100,      32'h104,      1'b0, 5'd0,  32'h0,        5'd8,   32'h10630001, 1'b1, 1'b1, 32'h104,      32'hAF,       32'h104};
      vec[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h08000040, 32'h200,      32'h204,      1'b1, 5'd5,  32'h7,        5'd3,   32'h0,        1'b0, 1'b1, 32'h0,        32'h0,        32'h0};
      vec[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        5'd8,   32'h0,        1'b0, 1'b1, 32'h0,        32'h0,        32'h0};
      vec[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h01000008, 32'h300,      32'h304,      1'b0, 5'd0,  32'h0,        5'd9,   32'h01000008, 1'b1, 1'b1, 32'h0,        32'h0,        32'h304};

      drive(vec[0]);
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vec[i]);
         @(posedge clk);
         #1;
         check("instruction", i, o_instruction, vec[i].e_instr);
         check("branch", i, {31'b0, branch}, {31'b0, vec[i].e_br});
         if (vec[i].chk_ba) check("branch_addr", i, branch_addr, vec[i].e_ba);
         check("debug_data", i, debug_data, vec[i].e_dbg);
         check("pc8", i, o_pc8, vec[i].e_pc8);
      end

      // JR R8 latched: field decode and combinational branch gating without a clock edge.
      @(negedge clk);
      step = 1'b0;
      #1;
      check("jr_branch_step0", 100, {31'b0, branch}, 32'h0);
      check("jr_opcode", 100, {26'b0, opcode}, 32'h0);
      check("jr_rs", 100, {27'b0, o_rs}, 32'd8);
      check("jr_rt", 100, {27'b0, o_rt}, 32'd0);
      check("jr_funct", 100, {26'b0, funct}, 32'h08);
      step = 1'b1;
      ifw  = 1'b0;
      #1;
      check("jr_branch_ifw0", 101, {31'b0, branch}, 32'h0);
      ifw = 1'b1;
      #1;
      check("jr_branch_live", 102, {31'b0, branch}, 32'h1);

      // BNE with negative immediate and both operands zero after reset: not taken.
      @(negedge clk);
      instruction = 32'h1509FFFF;
      pc4         = 32'h500;
      pc8         = 32'h504;
      @(posedge clk);
      #1;
      check("bne_imm_ext", 103, imm_ext, 32'hFFFFFFFF);
      check("bne_rs", 103, {27'b0, o_rs}, 32'd8);
      check("bne_rt", 103, {27'b0, o_rt}, 32'd9);
      check("bne_rd", 103, {27'b0, o_rd}, 32'h1F);
      check("bne_branch", 103, {31'b0, branch}, 32'h0);
      check("bne_rs_data", 103, rs_data, 32'h0);
      check("bne_rt_data", 103, rt_data, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
